// File: rtl/whack_pkg.sv
// Purpose: shared types and helpers for the whack-a-mole round engine.
// Latency: none (types, constants and a width function only).
// Backpressure: none.
package whack_pkg;

    typedef enum logic [1:0] {
        WAM_IDLE,
        WAM_SHOW,
        WAM_GAP,
        WAM_DONE
    } wam_state_t;

    // Galois feedback mask for the 16-bit mole-picking LFSR.
    localparam logic [15:0] WAM_LFSR_TAPS = 16'hB400;

    // Width of a mole index. Kept at least one bit so a 2-mole build still has an index bit.
    function automatic int WAM_IDX_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/whack_round_engine_if.sv
// Purpose: groups the game-pad inputs and the score/display outputs of the round engine.
// Latency: none (wires only).
// Backpressure: none; buttons and start are levels, pulses are single-cycle.
// master: pad wrapper side (drives ena/start/btn). slave: the engine (drives mole, score,
// round_idx, hit_pulse, miss_pulse, busy, game_end).
interface whack_round_engine_if #(
    parameter int N_MOLES     = 8,
    parameter int SCORE_W     = 8,
    parameter int GAME_ROUNDS = 30
);
    localparam int RI_W = $clog2(GAME_ROUNDS + 1);

    logic               ena;
    logic               start;
    logic [N_MOLES-1:0] btn;
    logic [N_MOLES-1:0] mole;
    logic [SCORE_W-1:0] score;
    logic [RI_W-1:0]    round_idx;
    logic               hit_pulse;
    logic               miss_pulse;
    logic               busy;
    logic               game_end;

    modport master (
        output ena, start, btn,
        input  mole, score, round_idx, hit_pulse, miss_pulse, busy, game_end
    );

    modport slave (
        input  ena, start, btn,
        output mole, score, round_idx, hit_pulse, miss_pulse, busy, game_end
    );

endinterface

// File: rtl/wam_lfsr.sv
// Purpose: 16-bit Galois LFSR used as the pseudo-random mole source.
// Latency: new value one cycle after a step with ena high.
// Backpressure: holds its value while ena is low.
// Ports: clk, rst_n (sync, active-low, loads SEED), ena (step), lfsr_state (current value).
module wam_lfsr
    import whack_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    output logic [15:0] lfsr_state
);

    logic [15:0] lfsr_next;

    // Right-shifting Galois form: the bit falling out of bit 0 folds the tap mask back in.
    assign lfsr_next = {1'b0, lfsr_state[15:1]} ^ (lfsr_state[0] ? WAM_LFSR_TAPS : 16'h0000);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_state <= SEED;
        end else if (ena) begin
            lfsr_state <= lfsr_next;
        end
    end

endmodule

// File: rtl/whack_round_engine.sv
// Purpose: whack-a-mole game core: sequences rounds, picks moles, scores hits and misses.
// Latency: start -> lit mole next cycle; button edge -> score/pulse/dark mole next cycle.
// Backpressure: ena low freezes all state and outputs; pulses never exceed one clock.
// Ports: clk, rst_n (sync, active-low), io (slave modport: ena/start/btn in; mole, score,
// round_idx, hit_pulse, miss_pulse, busy, game_end out).
// Build option: define WAM_MISS_PENALTY_EN to make each miss decrement the score (floor 0).
module whack_round_engine
    import whack_pkg::*;
#(
    parameter int          N_MOLES      = 8,
    parameter int          SCORE_W      = 8,
    parameter int          ROUND_CYCLES = 1000000,
    parameter int          GAP_CYCLES   = 200000,
    parameter int          GAME_ROUNDS  = 30,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    whack_round_engine_if.slave  io
);

    localparam int IDX_W   = WAM_IDX_W(N_MOLES);
    localparam int RI_W    = $clog2(GAME_ROUNDS + 1);
    localparam int CNT_MAX = (ROUND_CYCLES > GAP_CYCLES) ? ROUND_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX <= 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0]   ROUND_LOAD = CNT_W'(ROUND_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [RI_W-1:0]    LAST_ROUND = RI_W'(GAME_ROUNDS);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_MOLES - 1);
    localparam logic [N_MOLES-1:0] MOLE_ONE   = {{(N_MOLES-1){1'b0}}, 1'b1};

    wam_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_MOLES-1:0] mole_q, mole_d;
    logic [N_MOLES-1:0] btn_q, rise;
    logic [IDX_W-1:0]   prev_q, prev_d;
    logic [IDX_W-1:0]   raw_idx, pick_idx;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [RI_W-1:0]    round_q, round_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic [15:0]        lfsr;
    logic [15:0]        lfsr_mod;

    wam_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (io.ena),
        .lfsr_state (lfsr)
    );

    assign rise = io.btn & ~btn_q;

    // Candidate mole; bumped by one (with wrap) when it repeats the previous mole.
    always_comb begin
        lfsr_mod = lfsr % 16'(N_MOLES);
        raw_idx  = lfsr_mod[IDX_W-1:0];
        pick_idx = raw_idx;
        if (raw_idx == prev_q) begin
            pick_idx = (raw_idx == LAST_IDX) ? '0 : raw_idx + IDX_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mole_d  = mole_q;
        prev_d  = prev_q;
        score_d = score_q;
        round_d = round_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;

        unique case (state_q)
            WAM_IDLE, WAM_DONE: begin
                if (io.start) begin
                    score_d = '0;
                    round_d = '0;
                    mole_d  = MOLE_ONE << pick_idx;
                    prev_d  = pick_idx;
                    cnt_d   = ROUND_LOAD;
                    state_d = WAM_SHOW;
                end
            end
            WAM_SHOW: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Priority: hit, then wrong button, then timeout.
                if ((rise & mole_q) != '0) begin
                    hit_d = 1'b1;
                    if (score_q != '1) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end else if (rise != '0 || cnt_q == '0) begin
                    miss_d = 1'b1;
`ifdef WAM_MISS_PENALTY_EN
                    if (score_q != '0) begin
                        score_d = score_q - SCORE_W'(1);
                    end
`endif
                end
                if (hit_d || miss_d) begin
                    round_d = round_q + RI_W'(1);
                    mole_d  = '0;
                    cnt_d   = GAP_LOAD;
                    state_d = WAM_GAP;
                end
            end
            WAM_GAP: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = WAM_DONE;
                    end else begin
                        mole_d  = MOLE_ONE << pick_idx;
                        prev_d  = pick_idx;
                        cnt_d   = ROUND_LOAD;
                        state_d = WAM_SHOW;
                    end
                end
            end
            default: state_d = WAM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= WAM_IDLE;
            cnt_q   <= '0;
            mole_q  <= '0;
            prev_q  <= '0;
            score_q <= '0;
            round_q <= '0;
            btn_q   <= '1;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            // Pulses drop after one clock even when frozen, so a stall cannot stretch them.
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            if (io.ena) begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                mole_q  <= mole_d;
                prev_q  <= prev_d;
                score_q <= score_d;
                round_q <= round_d;
                btn_q   <= io.btn;
                hit_q   <= hit_d;
                miss_q  <= miss_d;
            end
        end
    end

    assign io.mole       = mole_q;
    assign io.score      = score_q;
    assign io.round_idx  = round_q;
    assign io.hit_pulse  = hit_q;
    assign io.miss_pulse = miss_q;
    assign io.busy       = (state_q == WAM_SHOW) || (state_q == WAM_GAP);
    assign io.game_end   = (state_q == WAM_DONE);

endmodule

// File: tb/tb_whack_round_engine.sv
// Purpose: directed bench for whack_round_engine with a round-level reference model.
// Latency: checks every cycle on the falling edge against the model.
// Backpressure: exercises ena stalls mid-round.
module tb_whack_round_engine;

    localparam int NM = 4;
    localparam int SW = 4;
    localparam int RC = 10;
    localparam int GC = 2;
    localparam int GR = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    whack_round_engine_if #(.N_MOLES(NM), .SCORE_W(SW), .GAME_ROUNDS(GR)) io();

    whack_round_engine #(
        .N_MOLES(NM), .SCORE_W(SW), .ROUND_CYCLES(RC), .GAP_CYCLES(GC),
        .GAME_ROUNDS(GR), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (game rules, one step per clock) ----------------
    int          m_phase;   // 0 idle, 1 mole shown, 2 dark gap, 3 game over
    int          m_elapsed; // enabled cycles spent in the current phase
    int          m_idx, m_prev, m_score, m_rounds;
    bit          m_hit, m_miss;
    logic [15:0] m_lfsr;
    logic [NM-1:0] m_btn_last, m_rise;
    bit          cmp_en = 1'b0;

    task pick_mole;
        int i;
        i = int'(m_lfsr) % NM;
        if (i == m_prev) i = (i + 1) % NM;
        m_idx  = i;
        m_prev = i;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_elapsed = 0; m_idx = 0; m_prev = 0;
            m_score = 0; m_rounds = 0; m_hit = 0; m_miss = 0;
            m_lfsr = 16'hACE1; m_btn_last = '1;
        end else if (!io.ena) begin
            m_hit = 0; m_miss = 0;
        end else begin
            m_rise = io.btn & ~m_btn_last;
            m_hit = 0; m_miss = 0;
            case (m_phase)
                0, 3: if (io.start) begin
                    m_score = 0; m_rounds = 0; pick_mole(); m_phase = 1; m_elapsed = 0;
                end
                1: begin
                    m_elapsed++;
                    if (m_rise[m_idx]) begin
                        m_hit = 1;
                        if (m_score < (2**SW) - 1) m_score++;
                    end else if (m_rise != 0 || m_elapsed == RC) begin
                        m_miss = 1;
`ifdef WAM_MISS_PENALTY_EN
                        if (m_score > 0) m_score--;
`endif
                    end
                    if (m_hit || m_miss) begin
                        m_rounds++; m_phase = 2; m_elapsed = 0;
                    end
                end
                2: begin
                    m_elapsed++;
                    if (m_elapsed == GC) begin
                        m_elapsed = 0;
                        if (m_rounds == GR) m_phase = 3;
                        else begin pick_mole(); m_phase = 1; end
                    end
                end
                default: m_phase = 0;
            endcase
            m_btn_last = io.btn;
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mole",       32'(io.mole),      (m_phase == 1) ? (32'd1 << m_idx) : 32'd0);
            chk("score",      32'(io.score),     32'(m_score));
            chk("round_idx",  32'(io.round_idx), 32'(m_rounds));
            chk("hit_pulse",  32'(io.hit_pulse), 32'(m_hit));
            chk("miss_pulse", 32'(io.miss_pulse),32'(m_miss));
            chk("busy",       32'(io.busy),      32'(m_phase == 1 || m_phase == 2));
            chk("game_end",   32'(io.game_end),  32'(m_phase == 3));
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        logic [NM-1:0] old_mole;
        int lit;
        bit went_dark;

        io.ena = 1'b1; io.start = 1'b0; io.btn = '0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_mole", 32'(io.mole), 0);
        chk("rst_score", 32'(io.score), 0);
        chk("rst_busy", 32'(io.busy), 0);
        chk("rst_game_end", 32'(io.game_end), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Game 1: timeout, hit on cycle 3, hit with a simultaneous wrong button.
        io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        chk("start_onehot", 32'($onehot(io.mole)), 1);
        chk("start_busy", 32'(io.busy), 1);
        chk("start_score", 32'(io.score), 0);

        lit = 1; went_dark = 0;
        for (int c = 0; c < 40 && !went_dark; c++) begin
            @(negedge clk);
            if (io.mole == '0) went_dark = 1; else lit++;
        end
        chk("timeout_lit_cycles", 32'(lit), 10);
        chk("timeout_miss", 32'(io.miss_pulse), 1);
        chk("timeout_score", 32'(io.score), 0);
        @(negedge clk);
        chk("gap_dark", 32'(io.mole), 0);
        @(negedge clk);
        chk("round2_onehot", 32'($onehot(io.mole)), 1);

        old_mole = NM'(1) << m_idx;
        repeat (2) @(negedge clk);
        io.btn = NM'(1) << m_idx;
        @(negedge clk);
        chk("hit_pulse_lit", 32'(io.hit_pulse), 1);
        chk("hit_score", 32'(io.score), 1);
        chk("hit_mole_dark", 32'(io.mole), 0);
        io.btn = '0;
        @(negedge clk);
        chk("hit_pulse_once", 32'(io.hit_pulse), 0);
        chk("gap2_dark", 32'(io.mole), 0);
        @(negedge clk);
        chk("new_mole_onehot", 32'($onehot(io.mole)), 1);
        chk("new_mole_differs", 32'(io.mole != old_mole), 1);

        io.btn = (NM'(1) << m_idx) | (NM'(1) << ((m_idx + 1) % NM));
        @(negedge clk);
        chk("both_hit", 32'(io.hit_pulse), 1);
        chk("both_no_miss", 32'(io.miss_pulse), 0);
        chk("both_score", 32'(io.score), 2);
        io.btn = '0;
        repeat (2) @(negedge clk);
        chk("g1_game_end", 32'(io.game_end), 1);
        chk("g1_rounds", 32'(io.round_idx), 3);
        chk("g1_score", 32'(io.score), 2);
        chk("g1_mole_dark", 32'(io.mole), 0);

        // Game 2: three straight hits.
        io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        chk("g2_score_clear", 32'(io.score), 0);
        chk("g2_round_clear", 32'(io.round_idx), 0);
        chk("g2_busy", 32'(io.busy), 1);
        for (int r = 0; r < 3; r++) begin
            io.btn = NM'(1) << m_idx;
            @(negedge clk);
            chk("g2_hit", 32'(io.hit_pulse), 1);
            io.btn = '0;
            repeat (2) @(negedge clk);
        end
        chk("g2_game_end", 32'(io.game_end), 1);
        chk("g2_rounds", 32'(io.round_idx), 3);
        chk("g2_score", 32'(io.score), 3);
        repeat (4) @(negedge clk);
        chk("g2_score_held", 32'(io.score), 3);
        chk("g2_end_held", 32'(io.game_end), 1);

        // Game 3: 5-cycle ena stall inside a round, then reset during the gap.
        io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        chk("g3_score_clear", 32'(io.score), 0);
        lit = 1; went_dark = 0;
        for (int c = 0; c < 60 && !went_dark; c++) begin
            if (c == 2) io.ena = 1'b0;
            if (c == 7) io.ena = 1'b1;
            @(negedge clk);
            if (io.mole == '0) went_dark = 1; else lit++;
        end
        io.ena = 1'b1;
        chk("stall_lit_cycles", 32'(lit), 15);
        chk("stall_miss", 32'(io.miss_pulse), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("gap_rst_mole", 32'(io.mole), 0);
        chk("gap_rst_score", 32'(io.score), 0);
        chk("gap_rst_round", 32'(io.round_idx), 0);
        chk("gap_rst_pulses", 32'({io.hit_pulse, io.miss_pulse}), 0);
        chk("gap_rst_busy", 32'(io.busy), 0);
        chk("gap_rst_end", 32'(io.game_end), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
